// File: rtl/secded84_serial_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : secded84_serial_rx_pkg
// Description : Shared constants, FSM encodings, error classes and the
//               syndrome helper for the (8,4) SECDED serial receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package secded84_serial_rx_pkg;

    // Codeword and data widths
    localparam int CW_W = 8;
    localparam int DW   = 4;

    // Bit positions inside code[7:0] = {par,d3,d2,d1,p4,d0,p2,p1}
    localparam int IDX_P1  = 0;
    localparam int IDX_P2  = 1;
    localparam int IDX_D0  = 2;
    localparam int IDX_P4  = 3;
    localparam int IDX_D1  = 4;
    localparam int IDX_D2  = 5;
    localparam int IDX_D3  = 6;
    localparam int IDX_PAR = 7;

    // Deserializer FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Error class of a decoded word
    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_SINGLE = 2'd1,
        ERR_PARITY = 2'd2,
        ERR_DOUBLE = 2'd3
    } err_class_e;

    // Syndrome {s4,s2,s1}; a non-zero value names the 1-based bit in error
    function automatic logic [2:0] calc_syndrome(input logic [6:0] c);
        logic s1, s2, s4;
        s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
        s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
        s4 = c[3] ^ c[4] ^ c[5] ^ c[6];
        return {s4, s2, s1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/secded84_decode_core.sv
`default_nettype none
// ============================================================================
// Module      : secded84_decode_core
// Description : Purely combinational (8,4) SECDED decoder: codeword in,
//               corrected nibble, syndrome and error flags out.
// Revision    : 1.0 - initial release
// ============================================================================
module secded84_decode_core
    import secded84_serial_rx_pkg::*;
(
    input  logic [CW_W-1:0] code_i,
    output logic [DW-1:0]   data_o,
    output logic [2:0]      syndrome_o,
    output logic            single_o,
    output logic            double_o,
    output logic            parity_o
);

    logic [2:0]  w_syn;
    logic        w_par;
    err_class_e  w_class;
    logic [6:0]  w_flip;
    logic [6:0]  w_fixed;

    assign w_syn = calc_syndrome(code_i[6:0]);
    assign w_par = ^code_i;

    // Classify from syndrome and overall parity
    always_comb begin
        w_class = ERR_NONE;
        if (w_syn != 3'd0 && w_par)       w_class = ERR_SINGLE;
        else if (w_syn == 3'd0 && w_par)  w_class = ERR_PARITY;
        else if (w_syn != 3'd0 && !w_par) w_class = ERR_DOUBLE;
    end

    // One-hot correction mask: only a single error flips code[syndrome-1]
    for (genvar i = 0; i < 7; i++) begin : g_flip
        assign w_flip[i] = (w_class == ERR_SINGLE) && (w_syn == 3'(i + 1));
    end

    assign w_fixed    = code_i[6:0] ^ w_flip;
    assign data_o     = {w_fixed[IDX_D3], w_fixed[IDX_D2], w_fixed[IDX_D1], w_fixed[IDX_D0]};
    assign syndrome_o = w_syn;
    assign single_o   = (w_class == ERR_SINGLE);
    assign double_o   = (w_class == ERR_DOUBLE);
    assign parity_o   = (w_class == ERR_PARITY);

endmodule
`default_nettype wire

// File: rtl/secded84_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : secded84_serial_rx
// Description : Bit-serial (8,4) SECDED receiver: deserializes LSB-first
//               codewords, decodes them, holds the result on a valid/ready
//               output and keeps saturating error statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module secded84_serial_rx
    import secded84_serial_rx_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_bit_valid,
    input  logic             i_bit,
    input  logic             i_sof,
    input  logic             i_ready,
    input  logic             i_clr_cnt,
    output logic             o_valid,
    output logic [3:0]       o_data,
    output logic [2:0]       o_syndrome,
    output logic             o_1bit_error,
    output logic             o_2bit_error,
    output logic             o_parity_error,
    output logic             o_overrun,
    output logic             o_sync_err,
    output logic [CNT_W-1:0] o_cnt_corr,
    output logic [CNT_W-1:0] o_cnt_uncorr
);

    logic [0:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [6:0]       sreg_q, sreg_d;
    logic             w_done;
    logic             w_sync_set;

    logic [CW_W-1:0]  w_code;
    logic [DW-1:0]    w_data;
    logic [2:0]       w_syn;
    logic             w_single, w_double, w_parity;

    logic             valid_q;
    logic [3:0]       data_q;
    logic [2:0]       syn_q;
    logic             e1_q, e2_q, pe_q;
    logic             ovr_q, sync_q;
    logic [CNT_W-1:0] corr_q, uncorr_q;

    // Deserializer next-state: sof always restarts, bit 7 completes the word
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        w_done     = 1'b0;
        w_sync_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_bit_valid && i_sof) begin
                    sreg_d  = {6'd0, i_bit};
                    cnt_d   = 3'd1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (i_bit_valid) begin
                    if (i_sof) begin
                        w_sync_set = 1'b1;
                        sreg_d     = {6'd0, i_bit};
                        cnt_d      = 3'd1;
                    end else if (cnt_q == 3'd7) begin
                        w_done  = 1'b1;
                        cnt_d   = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        sreg_d[cnt_q] = i_bit;
                        cnt_d         = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The parity bit is never stored; it is decoded straight off the input
    assign w_code = {i_bit, sreg_q};

    secded84_decode_core u_decode (
        .code_i     (w_code),
        .data_o     (w_data),
        .syndrome_o (w_syn),
        .single_o   (w_single),
        .double_o   (w_double),
        .parity_o   (w_parity)
    );

    // Deserializer state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            sreg_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
        end
    end

    // Output holding register: load when empty or being drained, else keep
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= 4'd0;
            syn_q   <= 3'd0;
            e1_q    <= 1'b0;
            e2_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else if (w_done && (!valid_q || i_ready)) begin
            valid_q <= 1'b1;
            data_q  <= w_data;
            syn_q   <= w_syn;
            e1_q    <= w_single;
            e2_q    <= w_double;
            pe_q    <= w_parity;
        end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Sticky overrun / sync flags; clear has priority over a set
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_cnt) begin
            ovr_q  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            if (w_done && valid_q && !i_ready) ovr_q  <= 1'b1;
            if (w_sync_set)                    sync_q <= 1'b1;
        end
    end

    // Saturating statistics, counting dropped words as well
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_cnt) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else if (w_done) begin
            if ((w_single || w_parity) && (corr_q != '1)) corr_q   <= corr_q + 1'b1;
            if (w_double && (uncorr_q != '1))             uncorr_q <= uncorr_q + 1'b1;
        end
    end

    assign o_valid        = valid_q;
    assign o_data         = data_q;
    assign o_syndrome     = syn_q;
    assign o_1bit_error   = e1_q;
    assign o_2bit_error   = e2_q;
    assign o_parity_error = pe_q;
    assign o_overrun      = ovr_q;
    assign o_sync_err     = sync_q;
    assign o_cnt_corr     = corr_q;
    assign o_cnt_uncorr   = uncorr_q;

endmodule
`default_nettype wire
